spi_xfer_ctrl: RTL and testbench

//  Master-side transfer sequencer for the SPI core. Accepts one word from the APB register side, then drives
//  ss/spi_mode so that baud_rate runs. Shifts mosi/miso on the baud generator's send/receive strobes and

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_shift_reg.sv | 68 ++++++
 rtl/spi_xfer_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master transfer sequencer:
//   state_t        sequencer states (IDLE/SETUP/XFER/HOLD/DONE)
//   SPI_MODE_*     encodings driven to the baud-rate generator
//   spi_mode_sel   maps enable / stop-in-wait inputs onto a SPI_MODE_* code
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
  localparam logic [1:0] SPI_MODE_WAIT = 2'b01;
  localparam logic [1:0] SPI_MODE_STOP = 2'b10;

  // Disabled beats waiting; waiting beats running.
  function automatic logic [1:0] spi_mode_sel(input logic spe, input logic spiswai);
    logic [1:0] mode;
    if (!spe) begin
      mode = SPI_MODE_STOP;
    end else if (spiswai) begin
      mode = SPI_MODE_WAIT;
    end else begin
      mode = SPI_MODE_RUN;
    end
    return mode;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// -----------------------------------------------------------------------------
// spi_shift_reg
// Transmit and receive shifters for one SPI word. The bit order is latched at
// load time so a mid-word change of the order input has no effect.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   load         capture load_data / load_lsbfe, present first bit, clear rx
//   load_data    word to transmit
//   load_lsbfe   1 = LSB first for this word
//   shift_tx     advance the transmit shifter and present the next bit
//   shift_rx     shift rx_bit into the receive shifter
//   rx_bit       serial input bit
//   tx_bit       registered serial output bit (drives mosi)
//   rx_word      receive shifter contents
// -----------------------------------------------------------------------------
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_lsbfe,
  input  logic              shift_tx,
  input  logic              shift_rx,
  input  logic              rx_bit,
  output logic              tx_bit,
  output logic [DATA_W-1:0] rx_word
);

  logic [DATA_W-1:0] tx_reg;
  logic              lsbfe_q;

  // Load / shift of the tx and rx words; tx_bit always holds the bit on the wire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_reg  <= '0;
      rx_word <= '0;
      lsbfe_q <= 1'b0;
      tx_bit  <= 1'b0;
    end else if (load) begin
      tx_reg  <= load_data;
      lsbfe_q <= load_lsbfe;
      tx_bit  <= load_lsbfe ? load_data[0] : load_data[DATA_W-1];
      rx_word <= '0;
    end else begin
      if (shift_tx) begin
        if (lsbfe_q) begin
          tx_reg <= {1'b0, tx_reg[DATA_W-1:1]};
          tx_bit <= tx_reg[1];
        end else begin
          tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
          tx_bit <= tx_reg[DATA_W-2];
        end
      end
      if (shift_rx) begin
        if (lsbfe_q) begin
          rx_word <= {rx_bit, rx_word[DATA_W-1:1]};
        end else begin
          rx_word <= {rx_word[DATA_W-2:0], rx_bit};
        end
      end
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
// Master-side SPI transfer sequencer. Takes one word from the register side,
// lowers ss, lets the baud generator run and shifts on its send/receive
// strobes, then returns the received word and raises the sticky spif flag.
// Optional feature macro: SPI_LSBFE_EN adds the lsbfe input (LSB-first select,
// sampled when the word is accepted); without it transfers are MSB first.
// Ports:
//   Pclk, PRESET_n          clock, synchronous active-low reset
//   spe, mstr, spiswai      enable, master mode, stop-in-wait request
//   tx_data/valid/ready     word handshake from the register side
//   rx_data, rx_valid       received word and its one-cycle update pulse
//   send/recv_strobe        edge strobes from the baud generator
//   miso, mosi, ss          serial lines (ss active-low)
//   spi_mode                00 run / 01 wait / 10 stop to the baud generator
//   busy, spif, spif_clr    activity, sticky completion flag and its clear
// -----------------------------------------------------------------------------
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic              Pclk,
  input  logic              PRESET_n,
  input  logic              spe,
  input  logic              mstr,
  input  logic              spiswai,
`ifdef SPI_LSBFE_EN
  input  logic              lsbfe,
`endif
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              send_strobe,
  input  logic              recv_strobe,
  input  logic              miso,
  output logic              mosi,
  output logic              ss,
  output logic [1:0]        spi_mode,
  output logic              busy,
  output logic              spif,
  input  logic              spif_clr
);

  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int CYC_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DATA_W);
  localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(SETUP_CYC - 1);
  localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'(HOLD_CYC - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [CYC_W-1:0]  cyc_cnt;
  logic              pend, pend_n;
  logic              accept, abort, freeze;
  logic              do_recv, do_send, done_fire;
  logic              lsbfe_sel;
  logic [DATA_W-1:0] rx_word;

`ifdef SPI_LSBFE_EN
  assign lsbfe_sel = lsbfe;
`else
  assign lsbfe_sel = 1'b0;
`endif

  assign tx_ready = (state == IDLE) & spe & mstr & ~spiswai;
  assign accept   = tx_valid & tx_ready;
  assign abort    = (state != IDLE) & (~spe | ~mstr);
  // Abort takes priority: a disabled block must release ss even while waiting.
  assign freeze   = (state != IDLE) & spiswai & ~abort;

  // Next-state, bit counter and pending-edge bookkeeping.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    pend_n    = pend;
    do_recv   = 1'b0;
    do_send   = 1'b0;
    done_fire = 1'b0;
    if (abort) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      pend_n    = 1'b0;
    end else if (freeze) begin
      state_n = state;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_n   = SETUP;
            bit_cnt_n = '0;
            pend_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
        SETUP: begin
          if (cyc_cnt == SETUP_LAST) begin
            state_n = XFER;
          end else begin
            state_n = SETUP;
          end
        end
        XFER: begin
          if (bit_cnt == BIT_LAST) begin
            state_n = HOLD;
          end else begin
            // Receive is handled first so a coincident send sees pend=1.
            if (recv_strobe) begin
              do_recv   = 1'b1;
              bit_cnt_n = bit_cnt + CNT_W'(1);
              pend_n    = 1'b1;
            end else begin
              do_recv = 1'b0;
            end
            // A send with nothing pending is the CPHA=1 leading edge: ignore it.
            if (send_strobe && pend_n && (bit_cnt_n < BIT_LAST)) begin
              do_send = 1'b1;
              pend_n  = 1'b0;
            end else begin
              do_send = 1'b0;
            end
          end
        end
        HOLD: begin
          if (cyc_cnt == HOLD_LAST) begin
            state_n = DONE;
          end else begin
            state_n = HOLD;
          end
        end
        DONE: begin
          state_n   = IDLE;
          done_fire = 1'b1;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge Pclk) begin
    if (!PRESET_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      pend     <= 1'b0;
      ss       <= 1'b1;
      busy     <= 1'b0;
      spi_mode <= SPI_MODE_STOP;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      spif     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      pend     <= pend_n;
      spi_mode <= spi_mode_sel(spe, spiswai);
      ss       <= ~((state_n == SETUP) | (state_n == XFER) | (state_n == HOLD));
      busy     <= (state_n != IDLE);
      rx_valid <= done_fire;
      if (state_n != state) begin
        cyc_cnt <= '0;
      end else if (!freeze && ((state == SETUP) || (state == HOLD))) begin
        cyc_cnt <= cyc_cnt + CYC_W'(1);
      end
      if (done_fire) begin
        rx_data <= rx_word;
      end
      // Completion beats a coincident clear.
      if (done_fire) begin
        spif <= 1'b1;
      end else if (spif_clr) begin
        spif <= 1'b0;
      end
    end
  end

  spi_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk        (Pclk),
    .rst_n      (PRESET_n),
    .load       (accept),
    .load_data  (tx_data),
    .load_lsbfe (lsbfe_sel),
    .shift_tx   (do_send),
    .shift_rx   (do_recv),
    .rx_bit     (miso),
    .tx_bit     (mosi),
    .rx_word    (rx_word)
  );

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_ctrl
// Bench for spi_xfer_ctrl. A small baud-generator model produces send/receive
// strobes while ss is low and the block is running; a slave model returns a
// chosen word (or mosi is looped back). Expected received words are queued
// when a transfer is issued and popped by a monitor on every rx_valid.
// -----------------------------------------------------------------------------
module tb_spi_xfer_ctrl;
  localparam int DW = 8;

  logic          Pclk = 1'b0;
  logic          PRESET_n, spe, mstr, spiswai;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid, send_strobe, recv_strobe, miso, mosi, ss;
  logic [1:0]    spi_mode;
  logic          busy, spif, spif_clr;
`ifdef SPI_LSBFE_EN
  logic          lsbfe;
`endif

  always #5 Pclk = ~Pclk;

  // Configuration shared between driver and baud/slave model
  bit            loop_en, cpha, lsb_mode;
  int            half_p;
  logic [DW-1:0] slave_word, mosi_word, cur_tx, last_rx;
  logic          miso_slv;
  int            gcnt, edges, kbits;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];

  assign miso = loop_en ? mosi : miso_slv;

  spi_xfer_ctrl dut (
    .Pclk(Pclk), .PRESET_n(PRESET_n), .spe(spe), .mstr(mstr), .spiswai(spiswai),
`ifdef SPI_LSBFE_EN
    .lsbfe(lsbfe),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .send_strobe(send_strobe), .recv_strobe(recv_strobe),
    .miso(miso), .mosi(mosi), .ss(ss), .spi_mode(spi_mode),
    .busy(busy), .spif(spif), .spif_clr(spif_clr)
  );

  function automatic int bitpos(input int k);
    return lsb_mode ? k : (DW - 1 - k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud generator + slave model: 2*DW sclk edges, half period half_p cycles
  initial begin
    send_strobe = 1'b0; recv_strobe = 1'b0; miso_slv = 1'b0;
    gcnt = 0; edges = 0; kbits = 0;
    forever begin
      @(negedge Pclk);
      #1;
      send_strobe = 1'b0;
      recv_strobe = 1'b0;
      if (PRESET_n !== 1'b1 || ss !== 1'b0) begin
        gcnt = 0; edges = 0; kbits = 0;
      end else if (spe && mstr && !spiswai && spi_mode == 2'b00 && edges < 2*DW) begin
        gcnt++;
        if (gcnt == half_p) begin
          gcnt = 0;
          // Sample edge is the leading edge for CPHA=0, trailing for CPHA=1
          if (((edges % 2) == 0) != cpha) begin
            miso_slv = slave_word[bitpos(kbits)];
            mosi_word[bitpos(kbits)] = mosi;
            kbits++;
            recv_strobe = 1'b1;
          end else begin
            send_strobe = 1'b1;
          end
          edges++;
        end
      end
    end
  end

  // Monitor: every rx_valid must match the oldest outstanding expectation
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge Pclk);
      if (PRESET_n === 1'b1 && rx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rx_valid: got rx_data %0h with nothing outstanding", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", rx_data, e);
          check("spif_on_done", spif, 1'b1);
        end
      end
    end
  end

  task automatic start_xfer(input logic [DW-1:0] tx, input bit loop, input logic [DW-1:0] slv,
                            input bit ph, input int hp, input bit lsb, input bit push);
    int n;
    n = 0;
    @(negedge Pclk);
    cpha = ph; half_p = hp; loop_en = loop; slave_word = slv; lsb_mode = lsb;
    mosi_word = '0; cur_tx = tx;
`ifdef SPI_LSBFE_EN
    lsbfe = lsb;
`endif
    tx_data = tx; tx_valid = 1'b1;
    while (!tx_ready && n < 100) begin
      @(negedge Pclk);
      n++;
    end
    if (!tx_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: tx_ready %0b required 1", tx_ready);
      tx_valid = 1'b0;
    end else begin
      if (push) begin
        exp_q.push_back(loop ? tx : slv);
        last_rx = loop ? tx : slv;
      end
      @(negedge Pclk);
      tx_valid = 1'b0;
      check("first_mosi", mosi, tx[bitpos(0)]);
      check("ss_low_after_accept", ss, 1'b0);
    end
  endtask

  task automatic wait_kbits(input int k);
    int n;
    n = 0;
    while (kbits < k && n < 1000) begin
      @(negedge Pclk);
      n++;
    end
    if (kbits < k) begin
      checks++; errors++;
      $display("FAIL bit_timeout: bits %0d required %0d", kbits, k);
    end
  endtask

  task automatic finish_xfer(input bit chk_mosi);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge Pclk);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
    if (chk_mosi) check("mosi_word", mosi_word, cur_tx);
  endtask

  initial begin
    int n, bad;
    logic [DW-1:0] t, s;
    bit l, p, b;
    PRESET_n = 1'b0; spe = 1'b0; mstr = 1'b0; spiswai = 1'b0;
    tx_data = '0; tx_valid = 1'b0; spif_clr = 1'b0;
    loop_en = 1'b1; cpha = 1'b0; lsb_mode = 1'b0; half_p = 3;
    slave_word = '0; mosi_word = '0; cur_tx = '0; last_rx = '0;
`ifdef SPI_LSBFE_EN
    lsbfe = 1'b0;
`endif
    repeat (3) @(negedge Pclk);
    // Reset values
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_ss", ss, 1'b1);
    check("rst_spi_mode", spi_mode, 2'b10);
    check("rst_busy", busy, 1'b0);
    check("rst_spif", spif, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    PRESET_n = 1'b1; spe = 1'b1; mstr = 1'b1;
    @(negedge Pclk);
    check("run_spi_mode", spi_mode, 2'b00);
    check("idle_tx_ready", tx_ready, 1'b1);

    // 1: A5 loopback, CPHA=0
    start_xfer(8'hA5, 1'b1, 8'h00, 1'b0, 3, 1'b0, 1'b1);
    finish_xfer(1'b1);

    // 2: CPHA=1, slave returns 3C while A5 goes out MSB first
    start_xfer(8'hA5, 1'b0, 8'h3C, 1'b1, 4, 1'b0, 1'b1);
    finish_xfer(1'b1);

    // 3: stop-in-wait after 3 bits for 20 cycles
    start_xfer(8'h5E, 1'b0, 8'hC3, 1'b0, 3, 1'b0, 1'b1);
    wait_kbits(3);
    @(negedge Pclk);
    spiswai = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Pclk);
      if (ss !== 1'b0 || busy !== 1'b1 || rx_valid !== 1'b0) bad++;
    end
    check("wait_frozen", bad, 0);
    check("wait_spi_mode", spi_mode, 2'b01);
    check("wait_tx_ready", tx_ready, 1'b0);
    spiswai = 1'b0;
    finish_xfer(1'b1);

    // 4: spe dropped after 4 bits aborts the transfer
    start_xfer(8'h96, 1'b1, 8'h00, 1'b0, 3, 1'b0, 1'b0);
    wait_kbits(4);
    @(negedge Pclk);
    spe = 1'b0;
    @(negedge Pclk);
    check("abort_ss", ss, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_spif_kept", spif, 1'b1);
    check("abort_rx_kept", rx_data, last_rx);
    spe = 1'b1;
    @(negedge Pclk);
    check("abort_tx_ready", tx_ready, 1'b1);
    repeat (5) @(negedge Pclk);

    // 5: spif clear collides with completion, then clears
    spif_clr = 1'b1;
    @(negedge Pclk);
    spif_clr = 1'b0;
    check("spif_cleared", spif, 1'b0);
    start_xfer(8'h69, 1'b1, 8'h00, 1'b0, 3, 1'b0, 1'b1);
    n = 0;
    while (!(busy && ss) && n < 1000) begin
      @(negedge Pclk);
      n++;
    end
    check("done_seen", busy & ss, 1'b1);
    spif_clr = 1'b1;
    @(negedge Pclk);
    check("spif_set_wins", spif, 1'b1);
    @(negedge Pclk);
    check("spif_clr_after", spif, 1'b0);
    spif_clr = 1'b0;
    finish_xfer(1'b1);

`ifdef SPI_LSBFE_EN
    // 6: LSB first, 01 loopback
    start_xfer(8'h01, 1'b1, 8'h00, 1'b0, 3, 1'b1, 1'b1);
    finish_xfer(1'b1);
`endif

    // Randomised transfers
    for (int i = 0; i < 10; i++) begin
      t = DW'($urandom);
      s = DW'($urandom);
      l = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
`ifdef SPI_LSBFE_EN
      b = 1'($urandom_range(0, 1));
`else
      b = 1'b0;
`endif
      start_xfer(t, l, s, p, int'($urandom_range(3, 5)), b, 1'b1);
      finish_xfer(1'b1);
    end

    // Reset in the middle of a transfer
    start_xfer(8'hE7, 1'b0, 8'h81, 1'b1, 3, 1'b0, 1'b0);
    wait_kbits(5);
    @(negedge Pclk);
    PRESET_n = 1'b0;
    @(negedge Pclk);
    check("mrst_rx_data", rx_data, 8'h00);
    check("mrst_ss", ss, 1'b1);
    check("mrst_busy", busy, 1'b0);
    check("mrst_spif", spif, 1'b0);
    check("mrst_rx_valid", rx_valid, 1'b0);
    PRESET_n = 1'b1;
    repeat (5) @(negedge Pclk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
